// File: rtl/mul_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// mul_share_ctrl_if : requester and response handshake bundle for mul_share_ctrl
// Revision: 1.0
// ============================================================================
interface mul_share_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_src1;
  logic [NREQ*WIDTH-1:0] req_src2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_result;

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// mul_share_ctrl : round-robin arbiter sharing one shift-add multiplier
// Revision: 1.0
// ============================================================================
module mul_share_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic            CLK_in,
  input  logic            RST_n,
  mul_share_ctrl_if.slave bus,
  output logic            busy
);

  localparam int                 c_PW      = 2 * WIDTH;
  localparam int                 c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
  localparam logic [IDW-1:0]     c_LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PW-1:0]    r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_PW-1:0]    r_acc;
  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [c_PW-1:0]    r_rsp_result;
  logic               r_busy;

  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_idx;
  logic [NREQ-1:0]    w_grant;
  logic [WIDTH-1:0]   w_src1;
  logic [WIDTH-1:0]   w_src2;
  logic [c_PW-1:0]    w_acc_next;

  // Scan from the farthest offset down so the nearest valid requester to rr_ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Reset is folded in so requesters see no accept while RST_n is held low.
  always_comb begin
    w_grant = '0;
    if (RST_n && (r_state == S_IDLE) && w_found) begin
      w_grant = NREQ'(1) << w_winner;
    end
  end

  assign w_src1     = bus.req_src1[w_winner*WIDTH +: WIDTH];
  assign w_src2     = bus.req_src2[w_winner*WIDTH +: WIDTH];
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_count      <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_src1};
            r_mplier <= w_src2;
            r_id     <= w_winner;
            r_acc    <= '0;
            r_count  <= '0;
            r_rr_ptr <= (w_winner == c_LAST_ID) ? '0 : w_winner + 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          r_count  <= r_count + 1'b1;
          // Last bit is folded into the captured result on the same edge.
          if (r_count == c_LAST) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_acc_next;
            r_rsp_id     <= r_id;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mul_share_ctrl : vectors, corner sequences and random traffic vs a model
// Revision: 1.0
// ============================================================================
module tb_mul_share_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic CLK_in = 1'b0;
  logic RST_n  = 1'b0;
  logic busy;

  mul_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  mul_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .CLK_in (CLK_in),
    .RST_n  (RST_n),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 CLK_in = ~CLK_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: phase, countdown, pointer, product by plain multiply
  int m_phase;
  int m_timer;
  int m_ptr;
  int m_id;
  int m_prod;
  int m_rv;
  int m_res;
  int m_rid;

  int dut_grants[$];
  int dut_rsp[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_timer = 0; m_ptr = 0; m_id = 0;
    m_prod  = 0; m_rv = 0; m_res = 0; m_rid = 0;
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int w;
    exp_ready = '0;
    w = pick(bus.req_valid);
    if (m_phase == 0 && w >= 0) exp_ready[w] = 1'b1;
  endfunction

  task automatic model_update(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] c1,
                              input logic [NREQ*WIDTH-1:0] c2, input logic rr);
    int w;
    logic [7:0] a, b;
    case (m_phase)
      0: begin
        w = pick(v);
        if (w >= 0) begin
          a = c1[w*WIDTH +: WIDTH];
          b = c2[w*WIDTH +: WIDTH];
          m_prod  = int'(a) * int'(b);
          m_id    = w;
          m_ptr   = (w + 1) % NREQ;
          m_phase = 1;
          m_timer = WIDTH;
        end
      end
      1: begin
        m_timer--;
        if (m_timer == 0) begin
          m_phase = 2; m_rv = 1; m_res = m_prod; m_rid = m_id;
        end
      end
      default: begin
        if (rr) begin m_phase = 0; m_rv = 0; end
      end
    endcase
  endtask

  // One clock: check combinational grant, advance model over the edge, check registers.
  task automatic step();
    logic [NREQ-1:0]       v;
    logic [NREQ*WIDTH-1:0] c1, c2;
    logic                  rr;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
    for (int k = 0; k < NREQ; k++)
      if (bus.req_ready[k]) begin dut_grants.push_back(k); break; end
    if (bus.rsp_valid && bus.rsp_ready)
      dut_rsp.push_back((int'(bus.rsp_id) << 16) | int'(bus.rsp_result));
    v = bus.req_valid; c1 = bus.req_src1; c2 = bus.req_src2; rr = bus.rsp_ready;
    @(posedge CLK_in);
    model_update(v, c1, c2, rr);
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rsp_id", 32'(bus.rsp_id), 32'(m_rid));
    chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_src1[i*WIDTH +: WIDTH] = a;
    bus.req_src2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 999;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.rsp_valid === 1'b1) begin cyc = c; break; end
    end
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (busy === 1'b0) break;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK_in);
    #1;
    RST_n = 1'b1;
    dut_grants.delete();
    dut_rsp.delete();
  endtask

  function automatic int grant_at(input int i);
    if (i < dut_grants.size()) return dut_grants[i];
    return -1;
  endfunction

  function automatic int rsp_at(input int i);
    if (i < dut_rsp.size()) return dut_rsp[i];
    return -1;
  endfunction

  initial begin
    int cyc;
    int r;

    tbl[0] = '{8'hA5, 8'h00, 16'h0000};
    tbl[1] = '{8'h00, 8'hC3, 16'h0000};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[3] = '{8'h01, 8'h01, 16'h0001};
    tbl[4] = '{8'h80, 8'h80, 16'h4000};
    tbl[5] = '{8'h12, 8'h34, 16'h03A8};
    tbl[6] = '{8'h0F, 8'h0F, 16'h00E1};
    tbl[7] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[8] = '{8'hAB, 8'hCD, 16'h88EF};
    tbl[9] = '{8'h02, 8'h80, 16'h0100};

    m_reset();
    bus.req_valid = '1;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge CLK_in);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    RST_n = 1'b1;

    // Single requester, maximum operands
    set_op(0, 8'hFF, 8'hFF);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    chk("t1_grant", 32'(grant_at(0)), 32'd0);
    wait_valid(cyc);
    chk("t1_latency", 32'(cyc), WIDTH);
    chk("t1_result", 32'(bus.rsp_result), 32'h0000FE01);
    chk("t1_id", 32'(bus.rsp_id), 32'd0);
    step();
    chk("t1_busy_after", 32'(busy), 32'd0);

    // All four continuously valid from rr_ptr=0
    do_reset();
    set_op(0, 8'h03, 8'h05);
    set_op(1, 8'h07, 8'h09);
    set_op(2, 8'h10, 8'h10);
    set_op(3, 8'h80, 8'h02);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 100 && dut_grants.size() < 5; c++) step();
    drain();
    chk("t2_rsp0", 32'(rsp_at(0)), 32'h0000000F);
    chk("t2_rsp1", 32'(rsp_at(1)), 32'h0001003F);
    chk("t2_rsp2", 32'(rsp_at(2)), 32'h00020100);
    chk("t2_rsp3", 32'(rsp_at(3)), 32'h00030100);
    chk("t2_wrap_grant", 32'(grant_at(4)), 32'd0);

    // Backpressure on the response holds it; a new request waits for release
    dut_grants.delete();
    set_op(2, 8'h12, 8'h34);
    set_op(1, 8'h05, 8'h06);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    wait_valid(cyc);
    chk("t3_latency", 32'(cyc), WIDTH);
    for (int h = 0; h < 5; h++) begin
      if (h == 1) bus.req_valid = 4'b0010;
      step();
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t3_hold_result", 32'(bus.rsp_result), 32'h000003A8);
      chk("t3_hold_id", 32'(bus.rsp_id), 32'd2);
    end
    chk("t3_no_early_ready", 32'(bus.req_ready), 32'd0);
    dut_grants.delete();
    bus.rsp_ready = 1'b1;
    step();
    chk("t3_none_on_release", 32'(dut_grants.size()), 32'd0);
    step();
    chk("t3_grant_after", 32'(grant_at(0)), 32'd1);
    drain();

    // Two contenders never starve each other
    do_reset();
    set_op(0, 8'h02, 8'h03);
    set_op(3, 8'h04, 8'h05);
    bus.req_valid = 4'b1001;
    for (int c = 0; c < 100 && dut_grants.size() < 4; c++) step();
    drain();
    chk("t4_g0", 32'(grant_at(0)), 32'd0);
    chk("t4_g1", 32'(grant_at(1)), 32'd3);
    chk("t4_g2", 32'(grant_at(2)), 32'd0);
    chk("t4_g3", 32'(grant_at(3)), 32'd3);

    // Vector table, each pair through a rotating requester
    for (int i = 0; i < 10; i++) begin
      r = i % NREQ;
      dut_grants.delete();
      set_op(r, tbl[i].a, tbl[i].b);
      bus.req_valid = NREQ'(1) << r;
      step();
      bus.req_valid = '0;
      chk("tbl_grant", 32'(grant_at(0)), 32'(r));
      wait_valid(cyc);
      chk("tbl_latency", 32'(cyc), WIDTH);
      chk("tbl_result", 32'(bus.rsp_result), 32'(tbl[i].p));
      chk("tbl_id", 32'(bus.rsp_id), 32'(r));
      step();
    end

    // Asynchronous reset in the middle of RUN
    set_op(0, 8'h0F, 8'h0F);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    repeat (3) step();
    bus.req_valid = 4'b1111;
    #2;
    RST_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_req_ready", 32'(bus.req_ready), 32'd0);
    m_reset();
    @(posedge CLK_in);
    @(posedge CLK_in);
    #1;
    chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = '0;
    RST_n = 1'b1;
    set_op(1, 8'h0F, 8'h0F);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    wait_valid(cyc);
    chk("t6_result", 32'(bus.rsp_result), 32'h000000E1);
    chk("t6_id", 32'(bus.rsp_id), 32'd1);
    step();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
